// File: rtl/irq_controller_if.sv
// Bundle of request, CPU handshake and configuration signals for irq_controller.
//   master : peripheral/CPU side (drives irq, handshakes, config writes)
//   slave  : the controller itself
// Signals:
//   irq               request lines, a rising edge is one request
//   available_for_int CPU can take an interrupt this cycle
//   int_done          one-cycle pulse when the CPU executes reti
//   int_occured       one-cycle interrupt pulse to the CPU
//   int_pc            handler PC, valid while int_occured is high
//   cfg_we/cfg_addr/cfg_wdata/cfg_rdata  configuration port
//   pending           latched, not-yet-serviced requests
//   in_service        a handler is running
//   active_id         index of the request being presented or serviced
interface irq_controller_if #(
    parameter int NUM_IRQ = 8
);
    logic [NUM_IRQ-1:0] irq;
    logic               available_for_int;
    logic               int_done;
    logic               int_occured;
    logic [9:0]         int_pc;
    logic               cfg_we;
    logic [3:0]         cfg_addr;
    logic [9:0]         cfg_wdata;
    logic [9:0]         cfg_rdata;
    logic [NUM_IRQ-1:0] pending;
    logic               in_service;
    logic [2:0]         active_id;

    modport master (
        output irq, available_for_int, int_done, cfg_we, cfg_addr, cfg_wdata,
        input  int_occured, int_pc, cfg_rdata, pending, in_service, active_id
    );

    modport slave (
        input  irq, available_for_int, int_done, cfg_we, cfg_addr, cfg_wdata,
        output int_occured, int_pc, cfg_rdata, pending, in_service, active_id
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt request controller for a CPU with a single interrupt line.
// Rising edges on irq[] are latched into pending[], filtered by a software
// mask, and the lowest enabled index is presented to the CPU as a one-cycle
// int_occured pulse with its handler PC on int_pc. Further requests are held
// off until the CPU signals reti on int_done.
// Ports:
//   clk  clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  irq_controller_if.slave (request lines, CPU handshake, config port)
// Config map: 0 = mask, 1..NUM_IRQ = vector[addr-1], 9 = drop counter.
// Optional feature macro: IRQ_CTRL_DROP_CNT_EN enables a saturating counter
// of requests lost because their line was already pending.
module irq_controller #(
    parameter int NUM_IRQ = 8
) (
    input logic             clk,
    input logic             rst,
    irq_controller_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FIRE, BUSY} state_t;

    state_t             state_reg, state_next;
    logic [NUM_IRQ-1:0] irq_q_reg;
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] mask_reg;
    logic [NUM_IRQ-1:0] edge_det, req, clear_vec;
    logic [9:0]         vector_rd [8];
    logic [9:0]         int_pc_reg;
    logic               int_occured_reg;
    logic [2:0]         active_id_reg;
    logic [2:0]         sel;
    logic               req_any;
    logic               load_sel;
    logic               fire_ack;
    logic [9:0]         rdata;

    assign edge_det = bus.irq & ~irq_q_reg;
    assign req      = pending_reg & mask_reg;
    assign req_any  = |req;

    // Fixed priority: scanning downward leaves the lowest set index in sel.
    always_comb begin
        sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) sel = 3'(i);
        end
    end

    // Next-state logic. A pulse the CPU did not take (available_for_int low
    // during FIRE) keeps the request pending and returns to IDLE to retry.
    always_comb begin
        state_next = state_reg;
        load_sel   = 1'b0;
        fire_ack   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_any && bus.available_for_int) begin
                    load_sel   = 1'b1;
                    state_next = FIRE;
                end
            end
            FIRE: begin
                if (bus.available_for_int) begin
                    fire_ack   = 1'b1;
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            BUSY: begin
                if (bus.int_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
        assign clear_vec[gi] = fire_ack && (active_id_reg == 3'(gi));
    end

    // A fresh edge wins over the clear of the line being acknowledged.
    assign pending_next = (pending_reg & ~clear_vec) | edge_det;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            irq_q_reg       <= '0;
            pending_reg     <= '0;
            mask_reg        <= '0;
            int_pc_reg      <= '0;
            int_occured_reg <= 1'b0;
            active_id_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            irq_q_reg       <= bus.irq;
            pending_reg     <= pending_next;
            int_occured_reg <= load_sel;
            // int_pc is captured once at selection, so later vector writes
            // cannot disturb a pulse or handler already in flight.
            if (load_sel) begin
                int_pc_reg    <= vector_rd[sel];
                active_id_reg <= sel;
            end
            if (bus.cfg_we && bus.cfg_addr == 4'd0) begin
                mask_reg <= bus.cfg_wdata[NUM_IRQ-1:0];
            end
        end
    end

    // Vector table; entries beyond NUM_IRQ are never written and stay zero.
    for (genvar gi = 0; gi < 8; gi++) begin : g_vec
        logic [9:0] vec_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vec_reg <= '0;
            end else if (bus.cfg_we && bus.cfg_addr == 4'(gi + 1) && gi < NUM_IRQ) begin
                vec_reg <= bus.cfg_wdata;
            end
        end
        assign vector_rd[gi] = vec_reg;
    end

`ifdef IRQ_CTRL_DROP_CNT_EN
    logic [9:0] drop_cnt_reg;
    logic       drop_evt;

    // An edge on a line that is still pending (and not being acknowledged
    // this cycle) merges into the existing request and is lost.
    assign drop_evt = |(edge_det & pending_reg & ~clear_vec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_reg <= '0;
        end else if (bus.cfg_we && bus.cfg_addr == 4'd9) begin
            drop_cnt_reg <= '0;
        end else if (drop_evt && drop_cnt_reg != 10'h3FF) begin
            drop_cnt_reg <= drop_cnt_reg + 10'd1;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (bus.cfg_addr == 4'd0) begin
            rdata[NUM_IRQ-1:0] = mask_reg;
        end else if (bus.cfg_addr <= 4'(NUM_IRQ)) begin
            rdata = vector_rd[3'(bus.cfg_addr - 4'd1)];
        end
`ifdef IRQ_CTRL_DROP_CNT_EN
        else if (bus.cfg_addr == 4'd9) begin
            rdata = drop_cnt_reg;
        end
`endif
    end

    assign bus.cfg_rdata   = rdata;
    assign bus.int_occured = int_occured_reg;
    assign bus.int_pc      = int_pc_reg;
    assign bus.active_id   = active_id_reg;
    assign bus.pending     = pending_reg;
    assign bus.in_service  = (state_reg == BUSY);

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a directed table, hand-written
// corner sequences and a randomized phase, all checked every cycle against a
// behavioural model of the controller kept in this file.
module tb_irq_controller;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irq_controller_if #(.NUM_IRQ(N)) bus();
    irq_controller #(.NUM_IRQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: request set, mask, vector table, and a description
    // of what the CPU currently sees (a pulse this cycle / a handler running).
    bit [7:0] m_pend, m_mask, m_prev;
    bit [9:0] m_vec [8];
    bit       m_pulse, m_handler;
    bit [9:0] m_pc;
    int       m_id;
    int       m_drop;

    typedef struct {
        logic [7:0] irq;
        logic       avail;
        logic       done;
        logic       we;
        logic [3:0] addr;
        logic [9:0] wdata;
        logic       exp_occ;
        logic [9:0] exp_pc;
        logic [2:0] exp_id;
        logic       exp_busy;
        logic [7:0] exp_pend;
    } vec_t;
    vec_t tbl [8];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0;
        for (int i = 0; i < 8; i++) m_vec[i] = '0;
        m_pulse = 0; m_handler = 0; m_pc = '0; m_id = 0; m_drop = 0;
    endfunction

    function automatic logic [9:0] model_rdata(input int addr);
        if (addr == 0) return {2'b00, m_mask};
        if (addr >= 1 && addr <= N) return m_vec[addr-1];
`ifdef IRQ_CTRL_DROP_CNT_EN
        if (addr == 9) return 10'(m_drop);
`endif
        return '0;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    function automatic void model_step();
        bit [7:0] edges;
        bit [7:0] cand;
        int       first;
        int       acked;
        bit       dropped;
        edges = bus.irq & ~m_prev;
        cand  = m_pend & m_mask;
        first = -1;
        acked = -1;
        for (int i = 0; i < N; i++) if (cand[i] && first < 0) first = i;
        if (m_pulse) begin
            m_pulse = 0;
            if (bus.available_for_int) begin
                acked = m_id;
                m_handler = 1;
            end
        end else if (m_handler) begin
            if (bus.int_done) m_handler = 0;
        end else if (first >= 0 && bus.available_for_int) begin
            m_pulse = 1;
            m_pc    = m_vec[first];
            m_id    = first;
        end
        dropped = 0;
        for (int i = 0; i < N; i++) if (edges[i] && m_pend[i] && i != acked) dropped = 1;
        if (acked >= 0) m_pend[acked] = 0;
        m_pend = m_pend | edges;
        if (bus.cfg_we && bus.cfg_addr == 0) m_mask = bus.cfg_wdata[7:0];
        if (bus.cfg_we && bus.cfg_addr >= 1 && bus.cfg_addr <= N) m_vec[bus.cfg_addr-1] = bus.cfg_wdata;
`ifdef IRQ_CTRL_DROP_CNT_EN
        if (bus.cfg_we && bus.cfg_addr == 9) m_drop = 0;
        else if (dropped && m_drop < 1023) m_drop++;
`endif
        m_prev = bus.irq;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".int_occured"}, 32'(bus.int_occured), 32'(m_pulse));
        chk({tag, ".int_pc"},      32'(bus.int_pc),      32'(m_pc));
        chk({tag, ".active_id"},   32'(bus.active_id),   32'(m_id));
        chk({tag, ".in_service"},  32'(bus.in_service),  32'(m_handler));
        chk({tag, ".pending"},     32'(bus.pending),     32'(m_pend));
        chk({tag, ".cfg_rdata"},   32'(bus.cfg_rdata),   32'(model_rdata(int'(bus.cfg_addr))));
    endtask

    task automatic set_in(input logic [7:0] irq, input logic avail, input logic done,
                          input logic we, input logic [3:0] addr, input logic [9:0] wdata);
        bus.irq = irq; bus.available_for_int = avail; bus.int_done = done;
        bus.cfg_we = we; bus.cfg_addr = addr; bus.cfg_wdata = wdata;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic wait_occ(input int limit, input string tag);
        int k = 0;
        while (bus.int_occured !== 1'b1 && k < limit) begin
            step(tag);
            k++;
        end
        chk({tag, ".arrived"}, 32'(bus.int_occured), 32'd1);
    endtask

    // Take the presented pulse, then end the handler with reti.
    task automatic finish_service(input string tag);
        set_in(8'h00, 1, 0, 0, 0, 0);
        step(tag);
        set_in(8'h00, 1, 1, 0, 0, 0);
        step(tag);
        bus.int_done = 0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //        irq    av dn we addr  wdata    occ pc      id busy pend
        tbl[0] = '{8'h00, 1, 0, 1, 4'd0, 10'h0FF, 0, 10'h000, 0, 0, 8'h00};
        tbl[1] = '{8'h00, 1, 0, 1, 4'd3, 10'h040, 0, 10'h000, 0, 0, 8'h00};
        tbl[2] = '{8'h04, 1, 0, 0, 4'd0, 10'h000, 0, 10'h000, 0, 0, 8'h04};
        tbl[3] = '{8'h04, 1, 0, 0, 4'd0, 10'h000, 1, 10'h040, 2, 0, 8'h04};
        tbl[4] = '{8'h00, 1, 0, 0, 4'd0, 10'h000, 0, 10'h040, 2, 1, 8'h00};
        tbl[5] = '{8'h00, 1, 0, 0, 4'd0, 10'h000, 0, 10'h040, 2, 1, 8'h00};
        tbl[6] = '{8'h00, 1, 1, 0, 4'd0, 10'h000, 0, 10'h040, 2, 0, 8'h00};
        tbl[7] = '{8'h00, 1, 0, 0, 4'd0, 10'h000, 0, 10'h040, 2, 0, 8'h00};

        set_in(8'h00, 1, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            set_in(tbl[k].irq, tbl[k].avail, tbl[k].done, tbl[k].we, tbl[k].addr, tbl[k].wdata);
            step("tbl");
            chk($sformatf("tbl%0d.occ", k),  32'(bus.int_occured), 32'(tbl[k].exp_occ));
            chk($sformatf("tbl%0d.pc", k),   32'(bus.int_pc),      32'(tbl[k].exp_pc));
            chk($sformatf("tbl%0d.id", k),   32'(bus.active_id),   32'(tbl[k].exp_id));
            chk($sformatf("tbl%0d.busy", k), 32'(bus.in_service),  32'(tbl[k].exp_busy));
            chk($sformatf("tbl%0d.pend", k), 32'(bus.pending),     32'(tbl[k].exp_pend));
        end

        // Simultaneous edges: lowest index first, the other after reti.
        set_in(8'h00, 1, 0, 1, 4'd6, 10'h100); step("prio");
        set_in(8'h00, 1, 0, 1, 4'd2, 10'h010); step("prio");
        set_in(8'h22, 1, 0, 0, 0, 0);          step("prio");
        set_in(8'h00, 1, 0, 0, 0, 0);
        wait_occ(8, "prio1");
        chk("prio1.pc", 32'(bus.int_pc), 32'h010);
        chk("prio1.id", 32'(bus.active_id), 32'd1);
        finish_service("prio1");
        wait_occ(8, "prio2");
        chk("prio2.pc", 32'(bus.int_pc), 32'h100);
        chk("prio2.id", 32'(bus.active_id), 32'd5);
        finish_service("prio2");

        // Masked request waits, then fires 2 cycles after unmasking.
        do_reset("mask.rst");
        set_in(8'h01, 1, 0, 0, 0, 0); step("mask");
        set_in(8'h00, 1, 0, 0, 0, 0);
        repeat (3) step("mask");
        chk("mask.pend0", 32'(bus.pending[0]), 32'd1);
        chk("mask.quiet", 32'(bus.int_occured), 32'd0);
        set_in(8'h00, 1, 0, 1, 4'd0, 10'h001); step("mask");
        chk("mask.write_cycle", 32'(bus.int_occured), 32'd0);
        set_in(8'h00, 1, 0, 0, 0, 0);          step("mask");
        chk("mask.latency", 32'(bus.int_occured), 32'd1);
        finish_service("mask");

        // CPU not available: hold off; pulse ignored during FIRE gets retried.
        set_in(8'h01, 0, 0, 1, 4'd1, 10'h3AA); step("avail");
        set_in(8'h00, 0, 0, 0, 0, 0);
        repeat (4) step("avail");
        chk("avail.held_pend", 32'(bus.pending[0]), 32'd1);
        chk("avail.held_quiet", 32'(bus.int_occured), 32'd0);
        bus.available_for_int = 1; step("avail");
        chk("avail.fire", 32'(bus.int_occured), 32'd1);
        chk("avail.pc", 32'(bus.int_pc), 32'h3AA);
        bus.available_for_int = 0; step("avail");
        chk("avail.ignored_occ", 32'(bus.int_occured), 32'd0);
        chk("avail.kept_pend", 32'(bus.pending[0]), 32'd1);
        bus.available_for_int = 1; step("avail");
        chk("avail.refire", 32'(bus.int_occured), 32'd1);
        step("avail");
        chk("avail.busy", 32'(bus.in_service), 32'd1);
        chk("avail.cleared", 32'(bus.pending[0]), 32'd0);

        // Reset while BUSY, irq[4] held high across it; reti afterwards is ignored.
        set_in(8'h10, 1, 0, 0, 4'd1, 0);
        do_reset("busyrst");
        set_in(8'h10, 1, 1, 0, 4'd1, 0); step("busyrst");
        chk("busyrst.edge_after", 32'(bus.pending), 32'h10);
        chk("busyrst.idle", 32'(bus.in_service), 32'd0);
        set_in(8'h00, 1, 0, 0, 0, 0);    step("busyrst");

`ifdef IRQ_CTRL_DROP_CNT_EN
        for (int k = 0; k < 3; k++) begin
            set_in(8'h08, 1, 0, 0, 0, 0); step("drop");
            set_in(8'h00, 1, 0, 0, 0, 0); step("drop");
        end
        set_in(8'h00, 1, 0, 0, 4'd9, 0); step("drop");
        chk("drop.count", 32'(bus.cfg_rdata), 32'd2);
        set_in(8'h00, 1, 0, 1, 4'd9, 0); step("drop");
        set_in(8'h00, 1, 0, 0, 4'd9, 0); step("drop");
        chk("drop.clear", 32'(bus.cfg_rdata), 32'd0);
`else
        set_in(8'h00, 1, 0, 1, 4'd9, 10'h3FF); step("nodrop");
        set_in(8'h00, 1, 0, 0, 4'd9, 0);       step("nodrop");
        chk("nodrop.addr9", 32'(bus.cfg_rdata), 32'd0);
`endif

        // Randomized traffic against the model.
        set_in(8'h00, 1, 0, 1, 4'd0, 10'($urandom)); step("rand");
        for (int k = 0; k < 1500; k++) begin
            bus.irq ^= 8'($urandom & $urandom & $urandom);
            bus.available_for_int = ($urandom_range(0, 3) != 0);
            bus.int_done  = ($urandom_range(0, 4) == 0);
            bus.cfg_we    = ($urandom_range(0, 9) == 0);
            bus.cfg_addr  = 4'($urandom_range(0, 15));
            bus.cfg_wdata = 10'($urandom);
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt request controller that drives the CPU's single-line interrupt protocol from up to eight external request lines. It edge-detects and latches requests, applies a software mask, and selects the highest-priority enabled request. It waits for `available_for_int`, then presents that request's 10-bit handler PC on `int_pc` with a one-cycle `int_occured` pulse. It then holds off further requests until the CPU signals handler completion (reti) on `int_done`. It sits beside the fetch/decode stage, between peripherals and the CPU.

## Interface
- `NUM_IRQ`, default 8: number of request lines, legal range 1..8.
- `clk`  in  1: clock; all logic is rising-edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `irq`  in  NUM_IRQ: request lines, synchronous to clk. A rising edge is one request.
- `available_for_int`  in  1: CPU accepts an interrupt this cycle.
- `int_done`  in  1: one-cycle pulse when the CPU executes reti.
- `int_occured`  out  1: one-cycle interrupt pulse to the CPU; registered.
- `int_pc`  out  10: handler PC; registered; valid while `int_occured`=1.
- `cfg_we`  in  1: configuration write strobe.
- `cfg_addr`  in  4: 0 = mask; 1..NUM_IRQ = vector[addr-1]; 9 = drop counter (macro only).
- `cfg_wdata`  in  10: write data. For the mask, bits [NUM_IRQ-1:0] are used.
- `cfg_rdata`  out  10: combinational read of `cfg_addr`; unmapped addresses read 0.
- `pending`  out  NUM_IRQ: latched, not-yet-serviced requests.
- `in_service`  out  1: a handler is running.
- `active_id`  out  3: index of the request being presented or serviced.

## Operation
- **Edge detect:** `irq_q` holds `irq` delayed one cycle. `pending[i]` is set when `irq[i]`=1 and `irq_q[i]`=0. Level after the edge is ignored.
- **Mask:** `mask[i]`=1 enables line i. A masked request stays pending and fires once the line is unmasked.
- **Priority:** fixed; the lowest index wins among `pending & mask`.
- **FSM states:** IDLE, FIRE, BUSY.
  - IDLE: if `(pending & mask)`≠0 and `available_for_int`=1, register `sel`, load `int_pc` ← vector[sel], set `int_occured`, go to FIRE.
  - FIRE: `int_occured`=1 for exactly this cycle.
    - If `available_for_int`=1: clear `pending[sel]`, go to BUSY.
    - Otherwise the CPU ignored the pulse: keep `pending[sel]` and go to IDLE to retry.
  - BUSY: `in_service`=1. On `int_done`=1, go to IDLE. No nesting.
- **Simultaneous events:**
  - A new edge on `sel` in the same cycle as its clear: the set wins and `pending[sel]` stays 1.
  - A config write in the same cycle as selection: the old mask/vector value is used.
  - `int_done` outside BUSY is ignored.
- **Config writes:**
  - Take effect the next cycle.
  - Vector writes during FIRE/BUSY do not alter the registered `int_pc`.
  - Writes to addresses >NUM_IRQ (other than 9 with the macro) are ignored.
- **Reset values:**
  - State IDLE; `int_occured`=0; `int_pc`=0; `active_id`=0; `in_service`=0.
  - `pending`=0; `irq_q`=0; `mask`=0; all vectors 0.
  - An irq held high through reset registers one edge on the first cycle after reset.
- **Reset mid-operation:** returns to IDLE immediately and clears everything; an interrupt in progress is lost.

## Timing
- Edge at cycle N → `pending` set at N+1 → IDLE decision at N+1 → `int_occured` high at N+2. Minimum latency is 2 cycles.
- `int_occured` is never high on two consecutive cycles.
- The minimum gap between pulses is 2 cycles (FIRE → IDLE → FIRE retry).
- After the BUSY → IDLE transition, the next request can fire 1 cycle later.
- `int_pc` is stable from the FIRE cycle until the next IDLE decision.

## Configuration
- `IRQ_CTRL_DROP_CNT_EN`:
  - **Defined:** a 10-bit saturating counter increments whenever an edge arrives on a line whose `pending` bit is already 1 and is not being cleared that cycle (a dropped request). It reads at `cfg_addr`=9, clears on any write to address 9, and resets to 0.
  - **Undefined:** no counter; address 9 reads 0 and writes are ignored.

## Test plan
- Reset; write mask=0x0FF and vector[2]=0x040; `available_for_int`=1; pulse `irq[2]` → `int_occured`=1 for one cycle exactly 2 cycles later, with `int_pc`=0x040 and `active_id`=2. `in_service`=1 until `int_done` is pulsed.
- Edges on `irq[5]` and `irq[1]` in the same cycle, vectors 0x100 and 0x010 → 0x010 is presented first. After `int_done`, 0x100 is presented.
- With mask=0x000, pulse `irq[0]` → no `int_occured`, `pending[0]`=1. Then write mask=0x001 → pulse follows 2 cycles after the write.
- Hold `available_for_int`=0 with a request pending → no pulse. Drop it low again during FIRE → `pending` is kept and the request re-fires once `available_for_int`=1.
- Assert `rst` during BUSY → all outputs and registers return to their reset values. An `int_done` afterwards has no effect.
- With `IRQ_CTRL_DROP_CNT_EN` defined: mask `irq[3]` and pulse it 3 times → counter reads 2 at address 9. Write address 9 → counter reads 0.
